// File: rtl/spi_exe_pkg.sv
// Shared types and constants for the parametrised SPI execution unit.
// Flag indices address the 5-bit status field that sits between result and frame count.
package spi_exe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_RESP,
    ST_WAIT_CS
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_NOT = 3'd7
  } op_t;

  localparam int NUM_FLAGS    = 5;
  localparam int FLAG_ERR     = 0;
  localparam int FLAG_ZF      = 1;
  localparam int FLAG_CF      = 2;
  localparam int FLAG_SF      = 3;
  localparam int FLAG_OF      = 4;
  localparam int OP_VALID_MAX = 7;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_alu_param.sv
// Combinational ALU for the SPI execution unit: one operation per frame plus flags.
// Invalid opcodes force a zero result with only ERR raised.
module spi_alu_param
  import spi_exe_pkg::*;
#(
  parameter int W   = 8,
  parameter int OPW = 4
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [OPW-1:0] op,
  output logic [W-1:0]   result,
  output logic           of,
  output logic           sf,
  output logic           cf,
  output logic           zf,
  output logic           err
);

  localparam int SHW = $clog2(W);

  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [SHW-1:0] shamt;
  logic [W:0]     shl_ext;
  logic [W:0]     shr_ext;
  logic           op_valid;
  logic [W-1:0]   res_core;
  logic           cf_core;
  logic           of_core;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHW-1:0];
  // One guard bit on each side catches the last bit shifted out; it stays 0 for a zero shift.
  assign shl_ext = {1'b0, a} << shamt;
  assign shr_ext = {a, 1'b0} >> shamt;

  assign op_valid = (32'(op) <= 32'(OP_VALID_MAX));

  always_comb begin
    res_core = '0;
    cf_core  = 1'b0;
    of_core  = 1'b0;
    case (op_t'(op[2:0]))
      OP_ADD: begin
        res_core = sum[W-1:0];
        cf_core  = sum[W];
        of_core  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        res_core = diff[W-1:0];
        cf_core  = diff[W];
        of_core  = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_AND: res_core = a & b;
      OP_OR:  res_core = a | b;
      OP_XOR: res_core = a ^ b;
      OP_SHL: begin
        res_core = shl_ext[W-1:0];
        cf_core  = shl_ext[W];
      end
      OP_SHR: begin
        res_core = shr_ext[W:1];
        cf_core  = shr_ext[0];
      end
      OP_NOT: res_core = ~a;
      default: res_core = '0;
    endcase
  end

  always_comb begin
    result = '0;
    of     = 1'b0;
    sf     = 1'b0;
    cf     = 1'b0;
    zf     = 1'b0;
    err    = 1'b1;
    if (op_valid) begin
      result = res_core;
      of     = of_core;
      sf     = res_core[W-1];
      cf     = cf_core;
      zf     = (res_core == '0);
      err    = 1'b0;
    end
  end

endmodule

// File: rtl/spi_exe_unit_param.sv
// SPI-slave (mode 0, MSB first) execution unit: loads {argA, argB, op}, runs the ALU,
// and shifts {result, flags, frame count} back out within the same chip-select window.
module spi_exe_unit_param
  import spi_exe_pkg::*;
#(
  parameter int W    = 8,
  parameter int OPW  = 4,
  parameter int CNTW = 3
) (
  input  logic i_sclk,
  input  logic i_rst,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_miso,
  output logic o_busy,
  output logic o_done
);

  localparam int IN_BITS  = 2 * W + OPW;
  localparam int OUT_BITS = W + NUM_FLAGS + CNTW;
  localparam int CNT_BITS = $clog2(max2(IN_BITS, OUT_BITS) + 1);
  localparam logic [CNT_BITS-1:0] LOAD_LAST = CNT_BITS'(IN_BITS - 1);
  localparam logic [CNT_BITS-1:0] RESP_LAST = CNT_BITS'(OUT_BITS - 1);

  state_t              state_q;
  state_t              state_d;
  logic [IN_BITS-1:0]  in_sr;
  logic [OUT_BITS-1:0] out_sr;
  logic [CNT_BITS-1:0] bit_cnt;
  logic [CNTW-1:0]     frame_cnt;
  logic [CNTW-1:0]     cnt_next;
  logic                done_q;

  logic [W-1:0]         alu_result;
  logic                 alu_of;
  logic                 alu_sf;
  logic                 alu_cf;
  logic                 alu_zf;
  logic                 alu_err;
  logic [NUM_FLAGS-1:0] flags;

  spi_alu_param #(
    .W   (W),
    .OPW (OPW)
  ) u_alu (
    .a      (in_sr[IN_BITS-1 -: W]),
    .b      (in_sr[OPW +: W]),
    .op     (in_sr[OPW-1:0]),
    .result (alu_result),
    .of     (alu_of),
    .sf     (alu_sf),
    .cf     (alu_cf),
    .zf     (alu_zf),
    .err    (alu_err)
  );

  always_comb begin
    flags           = '0;
    flags[FLAG_OF]  = alu_of;
    flags[FLAG_SF]  = alu_sf;
    flags[FLAG_CF]  = alu_cf;
    flags[FLAG_ZF]  = alu_zf;
    flags[FLAG_ERR] = alu_err;
  end

  assign cnt_next = frame_cnt + CNTW'(1);

  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // CS high in any active state abandons the frame; WAIT_CS needs it to rearm.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!i_cs) state_d = ST_LOAD;
      ST_LOAD: begin
        if (i_cs)                       state_d = ST_IDLE;
        else if (bit_cnt == LOAD_LAST)  state_d = ST_EXEC;
      end
      ST_EXEC: state_d = i_cs ? ST_IDLE : ST_RESP;
      ST_RESP: begin
        if (i_cs)                       state_d = ST_IDLE;
        else if (bit_cnt == RESP_LAST)  state_d = ST_WAIT_CS;
      end
      ST_WAIT_CS: if (i_cs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      in_sr     <= '0;
      out_sr    <= '0;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!i_cs) begin
            in_sr   <= {{(IN_BITS-1){1'b0}}, i_mosi};
            bit_cnt <= CNT_BITS'(1);
          end
        end
        ST_LOAD: begin
          if (!i_cs) begin
            in_sr   <= {in_sr[IN_BITS-2:0], i_mosi};
            bit_cnt <= bit_cnt + CNT_BITS'(1);
          end
        end
        ST_EXEC: begin
          if (!i_cs) begin
            out_sr    <= {alu_result, flags, cnt_next};
            frame_cnt <= cnt_next;
            bit_cnt   <= '0;
            done_q    <= 1'b1;
          end
        end
        ST_RESP: begin
          if (!i_cs) begin
            out_sr  <= {out_sr[OUT_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + CNT_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state so an async reset clears them without waiting for a clock.
  assign o_miso = (state_q == ST_RESP) && out_sr[OUT_BITS-1];
  assign o_busy = (state_q == ST_LOAD) || (state_q == ST_EXEC) || (state_q == ST_RESP);
  assign o_done = done_q;

endmodule

// File: tb/tb_spi_exe_unit_param.sv
// Self-checking bench: directed vectors, aborts, reset mid-response, counter wrap and
// randomized frames against an arithmetic reference model, on W=8 and W=16 instances.
module tb_spi_exe_unit_param;

  logic i_sclk = 1'b0;
  logic i_rst  = 1'b0;
  logic cs8    = 1'b1;
  logic mosi8  = 1'b0;
  logic cs16   = 1'b1;
  logic mosi16 = 1'b0;
  logic miso8, busy8, done8;
  logic miso16, busy16, done16;

  int vectors_applied = 0;
  int miscompares     = 0;
  int cnt8            = 0;
  int cnt16           = 0;

  typedef struct {
    string        name;
    bit           wide;
    logic [15:0]  a;
    logic [15:0]  b;
    logic [3:0]   op;
    logic [63:0]  exp_resp;
  } vec_t;

  vec_t vecs[4];

  always #5 i_sclk = ~i_sclk;

  spi_exe_unit_param #(.W(8), .OPW(4), .CNTW(3)) dut8 (
    .i_sclk (i_sclk),
    .i_rst  (i_rst),
    .i_cs   (cs8),
    .i_mosi (mosi8),
    .o_miso (miso8),
    .o_busy (busy8),
    .o_done (done8)
  );

  spi_exe_unit_param #(.W(16), .OPW(4), .CNTW(3)) dut16 (
    .i_sclk (i_sclk),
    .i_rst  (i_rst),
    .i_cs   (cs16),
    .i_mosi (mosi16),
    .o_miso (miso16),
    .o_busy (busy16),
    .o_done (done16)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: response computed from the operation definitions with plain integer arithmetic.
  function automatic logic [63:0] model(input bit wide, input longint a, input longint b,
                                        input int op, input int cnt);
    int     w, s;
    longint full, half, res, sa, sb, r;
    bit     of, sf, cf, zf, err;
    w    = wide ? 16 : 8;
    full = longint'(1) << w;
    half = full / 2;
    sa   = (a >= half) ? a - full : a;
    sb   = (b >= half) ? b - full : b;
    s    = int'(b % w);
    res  = 0; of = 0; cf = 0; err = 0;
    case (op)
      0: begin r = a + b; res = r % full; cf = (r >= full);
               r = sa + sb; of = (r >= half) || (r < -half); end
      1: begin res = (a - b + full) % full; cf = (a < b);
               r = sa - sb; of = (r >= half) || (r < -half); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin res = (a << s) % full; cf = (s > 0) && (((a >> (w - s)) & 1) == 1); end
      6: begin res = a >> s;          cf = (s > 0) && (((a >> (s - 1)) & 1) == 1); end
      7: res = full - 1 - a;
      default: err = 1;
    endcase
    sf = !err && (res >= half);
    zf = !err && (res == 0);
    return (res << 8) | (longint'(of) << 7) | (longint'(sf) << 6) | (longint'(cf) << 5) |
           (longint'(zf) << 4) | (longint'(err) << 3) | longint'(cnt % 8);
  endfunction

  task automatic drive(input bit wide, input logic cs, input logic mosi);
    if (wide) begin cs16 = cs; mosi16 = mosi; end
    else      begin cs8  = cs; mosi8  = mosi; end
  endtask

  function automatic logic get_miso(input bit wide); return wide ? miso16 : miso8; endfunction
  function automatic logic get_busy(input bit wide); return wide ? busy16 : busy8; endfunction
  function automatic logic get_done(input bit wide); return wide ? done16 : done8; endfunction

  // Drives one complete frame, collects the response, then holds CS low for hold+1 WAIT_CS cycles.
  task automatic applyStimulus(input bit wide, input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] op, input int hold,
                               output logic [63:0] resp, output int done_hits, output logic done_first);
    logic [63:0] frame;
    int w, nin, nout;
    w    = wide ? 16 : 8;
    nin  = 2 * w + 4;
    nout = w + 8;
    frame = wide ? {28'b0, a, b, op} : {44'b0, a[7:0], b[7:0], op};
    resp = '0;
    done_hits  = 0;
    done_first = 1'b0;
    for (int i = nin - 1; i >= 0; i--) begin
      @(negedge i_sclk);
      if (get_done(wide)) done_hits++;
      drive(wide, 1'b0, frame[i]);
    end
    @(negedge i_sclk);
    if (get_done(wide)) done_hits++;
    drive(wide, 1'b0, 1'($urandom));
    if (wide) cnt16++; else cnt8++;
    for (int j = 0; j < nout; j++) begin
      @(negedge i_sclk);
      resp = {resp[62:0], get_miso(wide)};
      if (get_done(wide)) begin
        done_hits++;
        if (j == 0) done_first = 1'b1;
      end
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge i_sclk);
      if (get_done(wide)) done_hits++;
      checkOutput("waitcs_miso", 64'(get_miso(wide)), 64'd0);
      checkOutput("waitcs_busy", 64'(get_busy(wide)), 64'd0);
    end
    drive(wide, 1'b1, 1'b0);
    @(negedge i_sclk);
  endtask

  task automatic runFrame(input string name, input bit wide, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] op, input int hold,
                          input logic [63:0] exp_resp);
    logic [63:0] resp;
    int          hits;
    logic        first;
    applyStimulus(wide, a, b, op, hold, resp, hits, first);
    checkOutput({name, "_resp"}, resp, exp_resp);
    checkOutput({name, "_done_first"}, 64'(first), 64'd1);
    checkOutput({name, "_done_count"}, 64'(hits), 64'd1);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [3:0]  rop;
    logic [63:0] exp_resp;
    int          hits;

    vecs[0] = '{"add_ovf",  1'b0, 16'h007F, 16'h0001, 4'h0, 64'h80C1};
    vecs[1] = '{"sub_brw",  1'b0, 16'h0000, 16'h0001, 4'h1, 64'hFF62};
    vecs[2] = '{"inv_op",   1'b0, 16'h0055, 16'h00AA, 4'hA, 64'h000B};
    vecs[3] = '{"w16_shl",  1'b1, 16'h0001, 16'h000F, 4'h5, 64'h800041};

    #1;
    checkOutput("rst_miso8", 64'(miso8), 64'd0);
    checkOutput("rst_busy8", 64'(busy8), 64'd0);
    checkOutput("rst_done8", 64'(done8), 64'd0);
    checkOutput("rst_busy16", 64'(busy16), 64'd0);
    repeat (2) @(negedge i_sclk);
    i_rst = 1'b1;
    @(negedge i_sclk);

    for (int v = 0; v < 4; v++)
      runFrame(vecs[v].name, vecs[v].wide, vecs[v].a, vecs[v].b, vecs[v].op, 0, vecs[v].exp_resp);

    $display("[TB] abort after 10 bits");
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_sclk);
      if (done8) hits++;
      drive(1'b0, 1'b0, 1'($urandom));
    end
    @(negedge i_sclk);
    checkOutput("abort_busy_in_load", 64'(busy8), 64'd1);
    drive(1'b0, 1'b1, 1'b0);
    @(negedge i_sclk);
    if (done8) hits++;
    checkOutput("abort_busy_idle", 64'(busy8), 64'd0);
    checkOutput("abort_no_done", 64'(hits), 64'd0);
    runFrame("after_abort", 1'b0, 16'h0001, 16'h0001, 4'h0, 0, 64'h0204);

    $display("[TB] reset during response");
    for (int i = 19; i >= 0; i--) begin
      @(negedge i_sclk);
      drive(1'b0, 1'b0, ((20'h7F010 >> i) & 20'h1) != 0);
    end
    @(negedge i_sclk);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge i_sclk);
    checkOutput("resp_busy", 64'(busy8), 64'd1);
    checkOutput("resp_miso_msb", 64'(miso8), 64'd1);
    #2 i_rst = 1'b0;
    #1;
    checkOutput("midrst_miso", 64'(miso8), 64'd0);
    checkOutput("midrst_busy", 64'(busy8), 64'd0);
    checkOutput("midrst_done", 64'(done8), 64'd0);
    cnt8  = 0;
    cnt16 = 0;
    @(negedge i_sclk);
    drive(1'b0, 1'b1, 1'b0);
    i_rst = 1'b1;
    @(negedge i_sclk);
    runFrame("post_rst", 1'b0, 16'h0001, 16'h0001, 4'h0, 0, 64'h0201);

    $display("[TB] hold CS low after response");
    runFrame("hold_cs", 1'b0, 16'h00F0, 16'h000F, 4'h3, 5, model(1'b0, 64'hF0, 64'h0F, 3, cnt8 + 1));

    $display("[TB] randomized frames with counter wrap");
    for (int k = 0; k < 12; k++) begin
      ra  = 16'($urandom_range(0, 255));
      rb  = 16'($urandom_range(0, 255));
      rop = 4'($urandom_range(0, 15));
      exp_resp = model(1'b0, longint'(ra), longint'(rb), int'(rop), cnt8 + 1);
      runFrame("rand8", 1'b0, ra, rb, rop, 0, exp_resp);
    end
    for (int k = 0; k < 5; k++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 4'($urandom_range(0, 15));
      exp_resp = model(1'b1, longint'(ra), longint'(rb), int'(rop), cnt16 + 1);
      runFrame("rand16", 1'b1, ra, rb, rop, 0, exp_resp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
